// File: rtl/vc_input_unit.sv
// vc_input_unit: per-input-port virtual-channel buffer for the mesh router.
// Each VC owns a small flit FIFO and an IDLE/ROUTING/VC_ALLOC/ACTIVE state
// machine with XY route compute, VA/SA handshakes and upstream credit return.
module vc_input_unit #(
    parameter int NUM_PORTS       = 5,
    parameter int NUM_VC          = 4,
    parameter int VC_DEPTH        = 4,
    parameter int FLIT_W          = 32,
    parameter int NUM_ROUTERS     = 16,
    parameter int ROUTERS_PER_ROW = 4,
    parameter int ROUTER_ID       = 0,
    parameter int ROUTER_ID_BITS  = $clog2(NUM_ROUTERS),
    parameter int PORT_BITS       = $clog2(NUM_PORTS),
    parameter int VC_BITS         = $clog2(NUM_VC)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_in_valid,
    input  logic [VC_BITS-1:0]            i_in_vc,
    input  logic [FLIT_W-1:0]             i_in_flit,
    output logic [NUM_VC-1:0]             o_vc_req,
    output logic [NUM_VC*PORT_BITS-1:0]   o_vc_route,
    input  logic [NUM_VC-1:0]             i_va_grant,
    input  logic [NUM_VC*VC_BITS-1:0]     i_va_out_vc,
    output logic [NUM_VC-1:0]             o_sa_req,
    input  logic [NUM_VC-1:0]             i_sa_grant,
    output logic                          o_out_valid,
    output logic [FLIT_W-1:0]             o_out_flit,
    output logic [PORT_BITS-1:0]          o_out_port,
    output logic [VC_BITS-1:0]            o_out_vc,
    output logic                          o_credit_valid,
    output logic [VC_BITS-1:0]            o_credit_vc,
    output logic                          o_protocol_error
);
    localparam int PTR_W = $clog2(VC_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ROUTING  = 2'd1;
    localparam logic [1:0] ST_VC_ALLOC = 2'd2;
    localparam logic [1:0] ST_ACTIVE   = 2'd3;

    localparam int CUR_ROW = ROUTER_ID / ROUTERS_PER_ROW;
    localparam int CUR_COL = ROUTER_ID % ROUTERS_PER_ROW;

    // Dimension-ordered routing: resolve the column first, then the row.
    function automatic logic [PORT_BITS-1:0] xy_route(input logic [ROUTER_ID_BITS-1:0] dest);
        int d_row;
        int d_col;
        d_row = int'(dest) / ROUTERS_PER_ROW;
        d_col = int'(dest) % ROUTERS_PER_ROW;
        if (d_col > CUR_COL)      return PORT_BITS'(3);
        else if (d_col < CUR_COL) return PORT_BITS'(2);
        else if (d_row > CUR_ROW) return PORT_BITS'(1);
        else if (d_row < CUR_ROW) return PORT_BITS'(0);
        else                      return PORT_BITS'(4);
    endfunction

    // Lowest set bit wins; used to serialise switch grants to one pop per cycle.
    function automatic logic [VC_BITS-1:0] lowest_idx(input logic [NUM_VC-1:0] g);
        logic [VC_BITS-1:0] idx;
        idx = {VC_BITS{1'b0}};
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            if (g[i]) idx = VC_BITS'(i);
        end
        return idx;
    endfunction

    logic [FLIT_W-1:0]    r_mem   [NUM_VC][VC_DEPTH];
    logic [PTR_W-1:0]     r_wptr  [NUM_VC];
    logic [PTR_W-1:0]     r_rptr  [NUM_VC];
    logic [CNT_W-1:0]     r_count [NUM_VC];
    logic [1:0]           r_state [NUM_VC];
    logic [PORT_BITS-1:0] r_route [NUM_VC];
    logic [VC_BITS-1:0]   r_ovc   [NUM_VC];

    logic                 r_out_valid;
    logic [FLIT_W-1:0]    r_out_flit;
    logic [PORT_BITS-1:0] r_out_port;
    logic [VC_BITS-1:0]   r_out_vc;
    logic                 r_credit_valid;
    logic [VC_BITS-1:0]   r_credit_vc;
    logic                 r_perr;

    logic [FLIT_W-1:0]    w_front   [NUM_VC];
    logic [CNT_W-1:0]     w_cnt_nxt [NUM_VC];
    logic [NUM_VC-1:0]    w_vc_req;
    logic [NUM_VC-1:0]    w_sa_req;
    logic [NUM_VC-1:0]    w_gnt;
    logic                 w_pop;
    logic [VC_BITS-1:0]   w_pop_vc;
    logic [FLIT_W-1:0]    w_pop_flit;
    logic                 w_pop_tail;
    logic                 w_push_full;
    logic                 w_push;
    logic                 w_multi_gnt;
    logic                 w_bad_head;

    // Per-VC decode of registered state: front flit, requests, next occupancy.
    always_comb begin
        w_bad_head = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            w_front[v]   = r_mem[v][r_rptr[v]];
            w_vc_req[v]  = (r_state[v] == ST_VC_ALLOC);
            w_sa_req[v]  = (r_state[v] == ST_ACTIVE) && (r_count[v] != {CNT_W{1'b0}});
            w_cnt_nxt[v] = r_count[v]
                         + CNT_W'(w_push && (i_in_vc == VC_BITS'(v)))
                         - CNT_W'(w_pop && (w_pop_vc == VC_BITS'(v)));
            w_bad_head   = w_bad_head | ((r_state[v] == ST_IDLE) &&
                           (r_count[v] != {CNT_W{1'b0}}) && !w_front[v][FLIT_W-2]);
            o_vc_route[v*PORT_BITS +: PORT_BITS] = r_route[v];
        end
    end

    // Write admission and grant arbitration; fullness uses the pre-pop count.
    always_comb begin
        w_push_full = (r_count[i_in_vc] == CNT_W'(VC_DEPTH));
        w_push      = i_in_valid && !w_push_full;
        w_gnt       = i_sa_grant & w_sa_req;
        w_pop       = (w_gnt != {NUM_VC{1'b0}});
        w_pop_vc    = lowest_idx(w_gnt);
        w_pop_flit  = w_front[w_pop_vc];
        w_pop_tail  = w_pop_flit[FLIT_W-1];
        w_multi_gnt = ((i_sa_grant & (i_sa_grant - NUM_VC'(1))) != {NUM_VC{1'b0}});
    end

    assign o_vc_req         = w_vc_req;
    assign o_sa_req         = w_sa_req;
    assign o_out_valid      = r_out_valid;
    assign o_out_flit       = r_out_flit;
    assign o_out_port       = r_out_port;
    assign o_out_vc         = r_out_vc;
    assign o_credit_valid   = r_credit_valid;
    assign o_credit_vc      = r_credit_vc;
    assign o_protocol_error = r_perr;

    // Flit storage; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[i_in_vc][r_wptr[i_in_vc]] <= i_in_flit;
        end
    end

    // Pointers, occupancy and the per-VC state machines.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                r_wptr[v]  <= {PTR_W{1'b0}};
                r_rptr[v]  <= {PTR_W{1'b0}};
                r_count[v] <= {CNT_W{1'b0}};
                r_state[v] <= ST_IDLE;
                r_route[v] <= {PORT_BITS{1'b0}};
                r_ovc[v]   <= {VC_BITS{1'b0}};
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (w_push && (i_in_vc == VC_BITS'(v))) r_wptr[v] <= r_wptr[v] + PTR_W'(1);
                if (w_pop && (w_pop_vc == VC_BITS'(v))) r_rptr[v] <= r_rptr[v] + PTR_W'(1);
                r_count[v] <= w_cnt_nxt[v];
                case (r_state[v])
                    ST_IDLE: begin
                        if (r_count[v] != {CNT_W{1'b0}}) r_state[v] <= ST_ROUTING;
                    end
                    ST_ROUTING: begin
                        r_route[v] <= xy_route(w_front[v][FLIT_W-3 -: ROUTER_ID_BITS]);
                        r_state[v] <= ST_VC_ALLOC;
                    end
                    ST_VC_ALLOC: begin
                        if (i_va_grant[v]) begin
                            r_ovc[v]   <= i_va_out_vc[v*VC_BITS +: VC_BITS];
                            r_state[v] <= ST_ACTIVE;
                        end
                    end
                    ST_ACTIVE: begin
                        if (w_pop && (w_pop_vc == VC_BITS'(v)) && w_pop_tail) begin
                            r_state[v] <= (w_cnt_nxt[v] != {CNT_W{1'b0}}) ? ST_ROUTING : ST_IDLE;
                        end
                    end
                    default: r_state[v] <= ST_IDLE;
                endcase
            end
        end
    end

    // Registered crossbar output, credit return and sticky protocol error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid    <= 1'b0;
            r_out_flit     <= {FLIT_W{1'b0}};
            r_out_port     <= {PORT_BITS{1'b0}};
            r_out_vc       <= {VC_BITS{1'b0}};
            r_credit_valid <= 1'b0;
            r_credit_vc    <= {VC_BITS{1'b0}};
            r_perr         <= 1'b0;
        end else begin
            r_perr <= r_perr | (i_in_valid & w_push_full) | w_multi_gnt | w_bad_head;
            if (w_pop) begin
                r_out_valid    <= 1'b1;
                r_out_flit     <= w_pop_flit;
                r_out_port     <= r_route[w_pop_vc];
                r_out_vc       <= r_ovc[w_pop_vc];
                r_credit_valid <= 1'b1;
                r_credit_vc    <= w_pop_vc;
            end else begin
                r_out_valid    <= 1'b0;
                r_credit_valid <= 1'b0;
            end
        end
    end
endmodule
